// File: rtl/sc_fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch PC unit: FSM states, trap causes,
// next-PC select codes and the exception handler entry points.
package sc_fetch_pc_unit_pkg;

   localparam logic [31:0] UNDEFINED_HANDLER_ADDR = 32'h8000_0180;
   localparam logic [31:0] OVERFLOW_HANDLER_ADDR  = 32'h8000_0200;

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StTrap = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CauseNone     = 2'b00,
      CauseUndef    = 2'b01,
      CauseOverflow = 2'b10
   } cause_e;

   typedef enum logic [2:0] {
      SelSeq      = 3'd0,
      SelBranch   = 3'd1,
      SelJump     = 3'd2,
      SelJr       = 3'd3,
      SelHold     = 3'd4,
      SelExcUndef = 3'd5,
      SelExcOvf   = 3'd6
   } npc_sel_e;

endpackage

// File: rtl/sc_next_pc_mux.sv
// Next-PC target computation and priority select for the RUN state.
module sc_next_pc_mux
   import sc_fetch_pc_unit_pkg::*;
(
   input  logic [31:0] i_pc,
   input  logic [31:0] i_pc_plus4,
   input  logic        i_stall,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_offset,
   input  logic        i_jump,
   input  logic [25:0] i_jump_target,
   input  logic        i_jump_reg,
   input  logic [31:0] i_jr_target,
   input  logic        i_exc_undef,
   input  logic        i_exc_overflow,
   output npc_sel_e    o_sel,
   output logic [31:0] o_next_pc
);

   logic [31:0] w_branch_target;
   logic [31:0] w_jump_target;
   logic [31:0] w_jr_target;

   assign w_branch_target = i_pc_plus4 + (i_branch_offset << 2);
   assign w_jump_target   = {i_pc_plus4[31:28], i_jump_target, 2'b00};
   assign w_jr_target     = i_jr_target & ~32'h0000_0003;

   // Exceptions beat stall; stall beats every redirect.
   always_comb begin
      if (i_exc_undef) begin
         o_sel = SelExcUndef;
      end else if (i_exc_overflow) begin
         o_sel = SelExcOvf;
      end else if (i_stall) begin
         o_sel = SelHold;
      end else if (i_jump_reg) begin
         o_sel = SelJr;
      end else if (i_jump) begin
         o_sel = SelJump;
      end else if (i_branch_taken) begin
         o_sel = SelBranch;
      end else begin
         o_sel = SelSeq;
      end
   end

   always_comb begin
      o_next_pc = i_pc_plus4;
      unique case (o_sel)
         SelExcUndef: o_next_pc = UNDEFINED_HANDLER_ADDR;
         SelExcOvf:   o_next_pc = OVERFLOW_HANDLER_ADDR;
         SelHold:     o_next_pc = i_pc;
         SelJr:       o_next_pc = w_jr_target;
         SelJump:     o_next_pc = w_jump_target;
         SelBranch:   o_next_pc = w_branch_target;
         default:     o_next_pc = i_pc_plus4;
      endcase
   end

endmodule

// File: rtl/sc_fetch_pc_unit.sv
// Fetch program counter with BOOT/RUN/TRAP sequencing, EPC/cause capture
// and a retired-instruction counter.
module sc_fetch_pc_unit
   import sc_fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_offset,
   input  logic        i_jump,
   input  logic [25:0] i_jump_target,
   input  logic        i_jump_reg,
   input  logic [31:0] i_jr_target,
   input  logic        i_exc_undef,
   input  logic        i_exc_overflow,
   input  logic        i_eret,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4,
   output logic [31:0] o_epc,
   output logic [1:0]  o_cause,
   output logic        o_trapped,
   output logic [31:0] o_instr_count
);

   state_e      r_state, w_state_d;
   logic [31:0] r_pc, w_pc_d;
   logic [31:0] r_epc, w_epc_d;
   cause_e      r_cause, w_cause_d;
   logic        r_trapped, w_trapped_d;
   logic [31:0] r_instr_count, w_instr_count_d;

   npc_sel_e    w_sel;
   logic [31:0] w_next_pc;
   logic        w_exc;

   assign o_pc_plus4 = r_pc + 32'd4;

   sc_next_pc_mux u_next_pc_mux (
      .i_pc            (r_pc),
      .i_pc_plus4      (o_pc_plus4),
      .i_stall         (i_stall),
      .i_branch_taken  (i_branch_taken),
      .i_branch_offset (i_branch_offset),
      .i_jump          (i_jump),
      .i_jump_target   (i_jump_target),
      .i_jump_reg      (i_jump_reg),
      .i_jr_target     (i_jr_target),
      .i_exc_undef     (i_exc_undef),
      .i_exc_overflow  (i_exc_overflow),
      .o_sel           (w_sel),
      .o_next_pc       (w_next_pc)
   );

   assign w_exc = (w_sel == SelExcUndef) || (w_sel == SelExcOvf);

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state       <= StBoot;
         r_pc          <= RESET_VECTOR;
         r_epc         <= 32'd0;
         r_cause       <= CauseNone;
         r_trapped     <= 1'b0;
         r_instr_count <= 32'd0;
      end else begin
         r_state       <= w_state_d;
         r_pc          <= w_pc_d;
         r_epc         <= w_epc_d;
         r_cause       <= w_cause_d;
         r_trapped     <= w_trapped_d;
         r_instr_count <= w_instr_count_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StBoot:  w_state_d = StRun;
         StRun:   if (w_exc) w_state_d = StTrap;
         StTrap:  if (i_eret) w_state_d = StRun;
         default: w_state_d = StBoot;
      endcase
   end

   always_comb begin
      w_pc_d          = r_pc;
      w_epc_d         = r_epc;
      w_cause_d       = r_cause;
      w_instr_count_d = r_instr_count;
      w_trapped_d     = (w_state_d == StTrap);
      unique case (r_state)
         StBoot: w_pc_d = RESET_VECTOR;
         StRun: begin
            if (w_exc) begin
               w_epc_d   = r_pc;
               w_cause_d = (w_sel == SelExcUndef) ? CauseUndef : CauseOverflow;
               w_pc_d    = w_next_pc;
            end else if (w_sel != SelHold) begin
               w_pc_d          = w_next_pc;
               w_instr_count_d = r_instr_count + 32'd1;
            end
         end
         StTrap: begin
            if (i_eret) begin
               w_pc_d    = r_epc + 32'd4;
               w_cause_d = CauseNone;
            end
         end
         default: ;
      endcase
   end

   assign o_pc          = r_pc;
   assign o_epc         = r_epc;
   assign o_cause       = r_cause;
   assign o_trapped     = r_trapped;
   assign o_instr_count = r_instr_count;

endmodule
